spi_target: RTL
===============

Name: spi_target

Overview:
SPI responder (mode 0: CPOL=0, CPHA=0, MSB first) on the same CPU bus interface as the SPI initiator. It lets the board act as an SPI peripheral to an external master. All SPI inputs are oversampled in the system clock through synchronisers; there is no second clock domain. It has single-entry TX and RX holding registers with status flags, overrun/underrun detection and an interrupt line.

Parameters:
SYNC_STAGES, 2, synchroniser depth for spi_clk/spi_mosi/spi_ss_n (>=2)
FILL_WORD, 32'hFFFFFFFF, word shifted out when no TX data is pending (underrun)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
we  in  4  byte write enables; any set bit = write
rd  in  1  read strobe
select  in  1  block select
addr  in  2  register address (CPU addr bits above [1:0])
wdata  in  32  write data
rdata  out  32  read data, combinational on addr
wbusy  out  1  constant 0; block never stalls writes
rbusy  out  1  constant 0; block never stalls reads
irq  out  1  interrupt request, level
spi_clk  in  1  SPI clock from external master, async
spi_mosi  in  1  master-out data, async
spi_ss_n  in  1  active-low target select, async
spi_miso  out  1  target-out data
spi_miso_oe  out  1  MISO output enable (1 only while selected)

Behaviour:
- Clock/reset: one clock. reset is synchronous and active-high; all state is cleared on the clk edge where reset=1.
- Constraint: spi_clk high and low phases each >= 4 clk periods.
- Register map:
  - addr0 DATA: read returns RX holding (endian-adjusted) and clears rx_valid when rd&select. Write loads TX holding with byte enables and sets tx_full.
  - addr1 STATUS: {27'b0, ss_active[4], tx_underrun[3], rx_overrun[2], tx_full[1], rx_valid[0]}. Write with we[0]: a 1 in bit 2 or bit 3 clears that flag (W1C).
  - addr2 CTRL: [1:0] size (0=8, 1=16, 2=24, 3=32 bits), written with we[0]. [16] big_endian, written with we[2]. [24] irq_en, written with we[3]. Reads back the same layout.
  - addr3: reads 32'hBBBBBBBB; writes ignored.
- Reset values: size=3, big_endian=1, irq_en=0, all flags 0, rx_hold=0, tx_hold=0, irq=0, spi_miso_oe=0, spi_miso=1. Synchroniser flops reset to idle level (ss_n=1, sclk=0).
- Endianness: little-endian byte-swaps on the CPU side, {b0,b1,b2,b3}, for both TX and RX, identical to the initiator.
- Alignment: TX bits go out from shift_out[31] downward, so an N-bit word uses shift_out[31:32-N]. RX words land right-justified in rx_hold[N-1:0]; upper bits are 0.
- Arming: a frame may start only after ss_n has been seen high (synced) at least once since reset. A low ss_n at reset exit is ignored until it rises.
- FSM, states IDLE, ACTIVE:
  - IDLE -> ACTIVE on synced ss_n falling edge while armed. On entry: load shift_out from tx_hold if tx_full (clear tx_full), else load FILL_WORD and set tx_underrun. Set bitcount = size_bits-1, shift_in=0, ss_active=1.
  - ACTIVE, synced sclk rising edge: shift_in <= {shift_in[30:0], mosi}. If bitcount==0, word completes: rx_hold <= shift_in value, and if rx_valid is already 1 set rx_overrun and overwrite; then rx_valid=1 and a reload is flagged. Otherwise bitcount decrements.
  - ACTIVE, synced sclk falling edge: if reload is flagged, load the next word as on entry and reset bitcount; else shift_out <= shift_out<<1.
  - ACTIVE -> IDLE on synced ss_n rising edge: a partial word is discarded (no rx update), ss_active=0. ss_n rising and an sclk edge in the same cycle: ss_n wins.
- spi_miso = shift_out[31]; spi_miso_oe = ss_active. When not active, spi_miso=1.
- Simultaneous events:
  - CPU DATA write in the same cycle as a TX load: wdata is used directly (bypass); tx_full stays 0 and there is no underrun.
  - CPU DATA read in the same cycle as word completion: rdata returns the old value, rx_valid stays 1 and there is no overrun.
  - CTRL size write during ACTIVE takes effect at the next word load.
- irq = irq_en & (rx_valid | rx_overrun | tx_underrun), registered, 1 cycle latency.

Decomposition:
- Package spi_pkg: ADDR_DATA/ADDR_STATUS/ADDR_CTRL constants; size encodings BYTE/HALFWORD/THREEBYTE/WORD; STATUS bit indices; state encoding. These are shared with the initiator.
- Sub-module spi_target_sync: SYNC_STAGES-deep synchroniser plus rise/fall edge detect, one instance per input (sclk, mosi, ss_n).

Test Plan:
- Reset with ss_n=1, then read all registers -> CTRL=0x00010003, STATUS=0, miso_oe=0, irq=0.
- size=BYTE, big_endian=1, write DATA=0xA5000000, master sends 0x3C -> MISO carries 0xA5 MSB first; rx_valid=1; DATA read=0x0000003C; rx_valid cleared after the read.
- size=WORD, big_endian=0, write DATA=0x11223344, master sends 0xDEADBEEF -> MISO bytes 44 33 22 11; DATA read=0xEFBEADDE.
- Two back-to-back bytes with no TX pending and no CPU read -> MISO=0xFF 0xFF; tx_underrun=1, rx_overrun=1; rx_hold=second byte; irq=1 with irq_en=1; W1C 0x0C clears both flags.
- ss_n rises after 5 of 8 bits -> rx_valid stays 0; next frame starts clean and receives 0x81 correctly.
- Reset asserted with ss_n held low, master clocks 0x55 -> no rx_valid; after ss_n goes high and low again, 0x55 is received.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI block definitions: register addresses, size codes,
// STATUS bit positions and the controller state encoding.
package spi_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_ID     = 2'd3;

    localparam logic [31:0] ID_WORD = 32'hBBBBBBBB;

    typedef enum logic [1:0] {
        BYTE      = 2'd0,
        HALFWORD  = 2'd1,
        THREEBYTE = 2'd2,
        WORD      = 2'd3
    } size_e;

    localparam int ST_RX_VALID    = 0;
    localparam int ST_TX_FULL     = 1;
    localparam int ST_RX_OVERRUN  = 2;
    localparam int ST_TX_UNDERRUN = 3;
    localparam int ST_SS_ACTIVE   = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    // Index of the last bit of a word: size*8 + 7
    function automatic logic [4:0] last_bit(input logic [1:0] sz);
        return {sz, 3'b111};
    endfunction

endpackage

// File: rtl/spi_target_sync.sv
// Multi-stage synchroniser for one asynchronous SPI input,
// with single-cycle rise/fall pulses on the synchronised level.
module spi_target_sync #(
    parameter int   STAGES   = 2,
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_pipe;
    logic              r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe <= {STAGES{IDLE_VAL}};
            r_prev <= IDLE_VAL;
        end else begin
            r_pipe <= {r_pipe[STAGES-2:0], i_d};
            r_prev <= r_pipe[STAGES-1];
        end
    end

    assign o_q    = r_pipe[STAGES-1];
    assign o_rise = r_pipe[STAGES-1] & ~r_prev;
    assign o_fall = ~r_pipe[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 responder with CPU register interface, single-entry
// TX/RX holding registers, overrun/underrun flags and level irq.
module spi_target
    import spi_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] FILL_WORD   = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  we,
    input  logic        rd,
    input  logic        select,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        wbusy,
    output logic        rbusy,
    output logic        irq,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    input  logic        spi_ss_n,
    output logic        spi_miso,
    output logic        spi_miso_oe
);

    logic w_sclk_q, w_sclk_rise, w_sclk_fall;
    logic w_mosi_q, w_mosi_rise, w_mosi_fall;
    logic w_ss_q, w_ss_rise, w_ss_fall;
    logic w_unused;

    spi_target_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sclk (
        .clk(clk), .reset(reset), .i_d(spi_clk),
        .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_target_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_mosi (
        .clk(clk), .reset(reset), .i_d(spi_mosi),
        .o_q(w_mosi_q), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    spi_target_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_ss (
        .clk(clk), .reset(reset), .i_d(spi_ss_n),
        .o_q(w_ss_q), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    assign w_unused = ^{w_sclk_q, w_mosi_rise, w_mosi_fall};

    state_e            r_state, w_state_nxt;
    size_e             r_size;
    logic              r_big, r_irq_en;
    logic              r_rx_valid, r_tx_full, r_rx_over, r_tx_under;
    logic              r_ss_active, r_armed, r_reload, r_irq;
    logic [SYNC_STAGES-1:0] r_fill;
    logic [31:0]       r_rx_hold, r_tx_hold, r_shift_out, r_shift_in;
    logic [4:0]        r_bitcnt;

    logic        w_start, w_stop, w_rx_edge, w_tx_edge;
    logic        w_load, w_done, w_bypass;
    logic        w_wr, w_data_wr, w_stat_wr, w_ctrl_wr, w_data_rd;
    logic        w_over_set, w_under_set;
    logic [31:0] w_shift_nxt, w_tx_view, w_tx_merge, w_tx_new, w_load_word;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_stop      = 1'b0;
        w_rx_edge   = 1'b0;
        w_tx_edge   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_ss_fall && r_armed) begin
                    w_state_nxt = ACTIVE;
                    w_start     = 1'b1;
                end
            end
            ACTIVE: begin
                // Deselect takes priority over a coincident clock edge
                if (w_ss_rise) begin
                    w_state_nxt = IDLE;
                    w_stop      = 1'b1;
                end else begin
                    w_rx_edge = w_sclk_rise;
                    w_tx_edge = w_sclk_fall;
                end
            end
            default: ;
        endcase
    end

    assign w_wr      = select & (|we);
    assign w_data_wr = w_wr & (addr == ADDR_DATA);
    assign w_stat_wr = w_wr & (addr == ADDR_STATUS) & we[0];
    assign w_ctrl_wr = w_wr & (addr == ADDR_CTRL);
    assign w_data_rd = rd & select & (addr == ADDR_DATA);

    assign w_tx_view = r_big ? r_tx_hold : bswap(r_tx_hold);

    always_comb begin
        w_tx_merge = w_tx_view;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) w_tx_merge[8*i +: 8] = wdata[8*i +: 8];
        end
    end

    assign w_tx_new    = r_big ? w_tx_merge : bswap(w_tx_merge);
    assign w_load      = w_start | (w_tx_edge & r_reload);
    assign w_done      = w_rx_edge & (r_bitcnt == 5'd0);
    assign w_shift_nxt = {r_shift_in[30:0], w_mosi_q};
    assign w_bypass    = w_load & w_data_wr & ~r_tx_full;
    assign w_under_set = w_load & ~r_tx_full & ~w_data_wr;
    assign w_over_set  = w_done & r_rx_valid & ~w_data_rd;

    always_comb begin
        w_load_word = FILL_WORD;
        if (r_tx_full)      w_load_word = r_tx_hold;
        else if (w_data_wr) w_load_word = w_tx_new;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_size   <= WORD;
            r_big    <= 1'b1;
            r_irq_en <= 1'b0;
            r_fill   <= '0;
            r_armed  <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr && we[0]) r_size   <= size_e'(wdata[1:0]);
            if (w_ctrl_wr && we[2]) r_big    <= wdata[16];
            if (w_ctrl_wr && we[3]) r_irq_en <= wdata[24];
            // Arm only once real (post-reset) samples show ss_n high
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            if (r_fill[SYNC_STAGES-1] && w_ss_q) r_armed <= 1'b1;
            r_irq <= r_irq_en & (r_rx_valid | r_rx_over | r_tx_under);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_hold  <= '0;
            r_tx_full  <= 1'b0;
            r_tx_under <= 1'b0;
            r_rx_hold  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_over  <= 1'b0;
        end else begin
            if (w_data_wr && !w_bypass) begin
                r_tx_hold <= w_tx_new;
                r_tx_full <= 1'b1;
            end else if (w_load && r_tx_full) begin
                r_tx_full <= 1'b0;
            end
            if (w_under_set)                 r_tx_under <= 1'b1;
            else if (w_stat_wr && wdata[3]) r_tx_under <= 1'b0;
            if (w_done) begin
                r_rx_hold  <= w_shift_nxt;
                r_rx_valid <= 1'b1;
            end else if (w_data_rd) begin
                r_rx_valid <= 1'b0;
            end
            if (w_over_set)                 r_rx_over <= 1'b1;
            else if (w_stat_wr && wdata[2]) r_rx_over <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift_out <= '1;
            r_shift_in  <= '0;
            r_bitcnt    <= '0;
            r_reload    <= 1'b0;
            r_ss_active <= 1'b0;
        end else begin
            if (w_load)         r_shift_out <= w_load_word;
            else if (w_tx_edge) r_shift_out <= {r_shift_out[30:0], 1'b0};
            if (w_start || w_done) r_shift_in <= '0;
            else if (w_rx_edge)    r_shift_in <= w_shift_nxt;
            if (w_load)                   r_bitcnt <= last_bit(r_size);
            else if (w_rx_edge && !w_done) r_bitcnt <= r_bitcnt - 5'd1;
            if (w_done)                 r_reload <= 1'b1;
            else if (w_load || w_stop)  r_reload <= 1'b0;
            if (w_start)     r_ss_active <= 1'b1;
            else if (w_stop) r_ss_active <= 1'b0;
        end
    end

    always_comb begin
        rdata = ID_WORD;
        unique case (addr)
            ADDR_DATA:   rdata = r_big ? r_rx_hold : bswap(r_rx_hold);
            ADDR_STATUS: rdata = {27'b0, r_ss_active, r_tx_under,
                                  r_rx_over, r_tx_full, r_rx_valid};
            ADDR_CTRL:   rdata = {7'b0, r_irq_en, 7'b0, r_big,
                                  14'b0, r_size};
            default:     rdata = ID_WORD;
        endcase
    end

    assign wbusy       = 1'b0;
    assign rbusy       = 1'b0;
    assign irq         = r_irq;
    assign spi_miso    = r_ss_active ? r_shift_out[31] : 1'b1;
    assign spi_miso_oe = r_ss_active;

endmodule
